// File: rtl/cfi_cmd_seq.sv
// Command sequencer that turns READ16/PROG16/UNLOCK_ERASE/CLR_STATUS requests
// into 16-bit Wishbone classic accesses to a CFI flash controller, with status polling.
module cfi_cmd_seq #(
  parameter int POLL_LIMIT = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [15:0] cmd_dat_i,
  output logic        cmd_ready_o,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_dat_o,
  output logic [7:0]  rsp_status_o,
  output logic        rsp_err_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [1:0] OP_RD = 2'b00, OP_PRG = 2'b01, OP_UE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP, S_DONE} state_t;

  state_t        r_state, w_nxt;
  logic          r_live;
  logic [1:0]    r_op;
  logic [31:1]   r_adr;
  logic [15:0]   r_dat;
  logic [1:0]    r_step;
  logic          r_poll;
  logic [PW-1:0] r_pcnt;
  logic [15:0]   r_rsp_dat;
  logic [7:0]    r_rsp_st;
  logic          r_rsp_err;

  logic          w_we, w_zero, w_last, w_bus, w_accept, w_pready, w_ptimeout;
  logic [15:0]   w_wd, w_rd16;
  logic [31:0]   w_acc_adr;
  logic          w_unused;

  assign w_unused = cmd_adr_i[0];

  // Current access of the sequence, selected by op, step and poll phase
  always_comb begin
    w_we   = 1'b1;
    w_zero = 1'b0;
    w_last = 1'b0;
    w_wd   = '0;
    if (r_poll) begin
      w_zero = 1'b1;
      w_we   = ~r_step[0];
      w_wd   = 16'h0070;
    end else begin
      case (r_op)
        OP_RD: begin
          w_we   = ~r_step[0];
          w_wd   = 16'h00FF;
          w_last = r_step[0];
        end
        OP_PRG: begin
          w_wd   = r_step[0] ? r_dat : 16'h0040;
          w_last = r_step[0];
        end
        OP_UE: begin
          case (r_step)
            2'd0:    w_wd = 16'h0060;
            2'd1:    w_wd = 16'h00D0;
            2'd2:    w_wd = 16'h0020;
            default: w_wd = 16'h00D0;
          endcase
          w_last = (r_step == 2'd3);
        end
        default: begin
          w_zero = 1'b1;
          w_wd   = 16'h0050;
          w_last = 1'b1;
        end
      endcase
    end
  end

  assign w_acc_adr  = w_zero ? 32'h0 : {r_adr, 1'b0};
  assign w_rd16     = w_acc_adr[1] ? wbm_dat_i[15:0] : wbm_dat_i[31:16];
  assign w_pready   = w_rd16[7];
  assign w_ptimeout = (r_pcnt == PW'(POLL_LIMIT - 1));
  assign w_bus      = (r_state == S_BUS);
  assign w_accept   = cmd_valid_i & cmd_ready_o;

  assign cmd_ready_o  = r_live & (r_state == S_IDLE);
  assign rsp_valid_o  = (r_state == S_DONE);
  assign rsp_dat_o    = r_rsp_dat;
  assign rsp_status_o = r_rsp_st;
  assign rsp_err_o    = r_rsp_err;

  assign wbm_stb_o = w_bus;
  assign wbm_cyc_o = w_bus;
  assign wbm_we_o  = w_bus & w_we;
  assign wbm_adr_o = w_bus ? w_acc_adr : 32'h0;
  assign wbm_sel_o = w_bus ? (w_acc_adr[1] ? 4'h3 : 4'hC) : 4'h0;
  assign wbm_dat_o = (w_bus & w_we) ? {w_wd, w_wd} : 32'h0;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_nxt = S_BUS;
      S_BUS: if (wbm_ack_i) begin
        if (r_poll && !w_we)
          w_nxt = (w_pready || w_ptimeout) ? S_DONE : S_GAP;
        else if (w_last && (r_op == OP_RD || r_op == 2'b11))
          w_nxt = S_DONE;
        else
          w_nxt = S_GAP;
      end
      S_GAP:   w_nxt = S_BUS;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) r_state <= S_IDLE;
    else             r_state <= w_nxt;
  end

  // Response registers change only on the edge entering DONE, so they hold between responses
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_live    <= 1'b0;
      r_op      <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_step    <= '0;
      r_poll    <= 1'b0;
      r_pcnt    <= '0;
      r_rsp_dat <= '0;
      r_rsp_st  <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (r_state == S_IDLE && w_accept) begin
        r_op   <= cmd_op_i;
        r_adr  <= cmd_adr_i[31:1];
        r_dat  <= cmd_dat_i;
        r_step <= '0;
        r_poll <= 1'b0;
        r_pcnt <= '0;
      end else if (w_bus && wbm_ack_i) begin
        if (r_poll) begin
          r_step <= {1'b0, ~r_step[0]};
          if (!w_we) begin
            r_pcnt <= r_pcnt + PW'(1);
            if (w_pready || w_ptimeout) begin
              r_rsp_dat <= '0;
              r_rsp_st  <= w_rd16[7:0];
              r_rsp_err <= w_pready ? (w_rd16[5] | w_rd16[4] | w_rd16[3] | w_rd16[1]) : 1'b1;
            end
          end
        end else if (w_last) begin
          r_step <= '0;
          if (r_op == OP_PRG || r_op == OP_UE) begin
            r_poll <= 1'b1;
          end else begin
            r_rsp_dat <= (r_op == OP_RD) ? w_rd16 : 16'h0;
            r_rsp_st  <= '0;
            r_rsp_err <= 1'b0;
          end
        end else begin
          r_step <= r_step + 2'd1;
        end
      end
    end
  end
endmodule
